// File: rtl/div_pkg.sv
// Shared definitions for the radix-2^R divider: op encodings, FSM states and op decode helpers.
package div_pkg;

   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_ITER = 2'd1,
      DIV_FIX  = 2'd2,
      DIV_DONE = 2'd3
   } div_state_e;

   // Bit 0 set means unsigned, bit 1 set means remainder.
   function automatic logic is_signed_op(input logic [1:0] op);
      return ~op[0];
   endfunction

   function automatic logic is_rem_op(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/div_digit_sel.sv
// Combinational radix-2^R digit selection: picks the largest multiple of the divisor that fits
// the partial remainder and returns the digit together with the reduced partial remainder.
module div_digit_sel #(
   parameter int XLEN       = 32,
   parameter int RADIX_LOG2 = 4
) (
   input  logic [XLEN+RADIX_LOG2-1:0] prem_i,
   input  logic [XLEN-1:0]            divisor_i,
   output logic [RADIX_LOG2-1:0]      digit_o,
   output logic [XLEN-1:0]            prem_o
);
   localparam int PW = XLEN + RADIX_LOG2;
   localparam int ND = 1 << RADIX_LOG2;

   logic [PW-1:0]         dvs_ext;
   logic [PW-1:0]         mult [ND];
   logic [ND-1:1]         fits;
   logic [RADIX_LOG2-1:0] diff_unused;

   assign dvs_ext = {{RADIX_LOG2{1'b0}}, divisor_i};
   assign mult[0] = '0;

   for (genvar d = 1; d < ND; d++) begin : g_mult
      assign mult[d] = PW'(d) * dvs_ext;
      assign fits[d] = (prem_i >= mult[d]);
   end

   // Multiples grow monotonically, so the highest fitting index is the digit.
   always_comb begin
      digit_o = '0;
      for (int i = 1; i < ND; i++) begin
         if (fits[i]) digit_o = RADIX_LOG2'(i);
      end
   end

   // The reduced remainder is always below the divisor, so the top R bits are zero.
   assign {diff_unused, prem_o} = prem_i - mult[digit_o];

endmodule

// File: rtl/div_radix_param.sv
// Iterative radix-2^R divider for DIV/DIVU/REM/REMU with RISC-V corner-case semantics.
// Define DIV_EARLY_OUT_EN to skip leading all-zero dividend digit groups at accept.
module div_radix_param
   import div_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int RADIX_LOG2 = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);
   // Handshake: a transfer happens on an edge where valid && ready; valid never waits on ready,
   // and once out_valid is high result is held until the transfer (or a kill) takes place.
   localparam int N_ITER = XLEN / RADIX_LOG2;
   localparam int CNT_W  = $clog2(N_ITER + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);
   localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e       state_q, state_d;
   logic             rem_op_q, rem_op_d;
   logic             neg_quot_q, neg_quot_d;
   logic             neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]  dvd_q, dvd_d;
   logic [XLEN-1:0]  dvs_q, dvs_d;
   logic [XLEN-1:0]  prem_q, prem_d;
   logic [XLEN-1:0]  quot_q, quot_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic                  accept, signed_op, dvd_neg, dvs_neg, div_zero, overflow;
   logic [XLEN-1:0]       dvd_abs, dvs_abs;
   logic [CNT_W-1:0]      skip_groups;
   logic [RADIX_LOG2-1:0] step_digit;
   logic [XLEN-1:0]       step_prem;

   assign accept    = in_valid && in_ready && !kill;
   assign signed_op = is_signed_op(op);
   assign dvd_neg   = signed_op && dividend[XLEN-1];
   assign dvs_neg   = signed_op && divisor[XLEN-1];
   assign dvd_abs   = dvd_neg ? -dividend : dividend;
   assign dvs_abs   = dvs_neg ? -divisor : divisor;
   assign div_zero  = (divisor == '0);
   assign overflow  = signed_op && (dividend == MOST_NEG) && (divisor == '1);

`ifdef DIV_EARLY_OUT_EN
   // Number of all-zero digit groups above the most significant non-zero group.
   always_comb begin
      skip_groups = CNT_W'(N_ITER);
      for (int g = 0; g < N_ITER; g++) begin
         if (dvd_abs[g*RADIX_LOG2 +: RADIX_LOG2] != '0) skip_groups = CNT_W'(N_ITER - 1 - g);
      end
   end
`else
   assign skip_groups = '0;
`endif

   div_digit_sel #(
      .XLEN       (XLEN),
      .RADIX_LOG2 (RADIX_LOG2)
   ) u_digit_sel (
      .prem_i    ({prem_q, dvd_q[XLEN-1 -: RADIX_LOG2]}),
      .divisor_i (dvs_q),
      .digit_o   (step_digit),
      .prem_o    (step_prem)
   );

   always_comb begin
      state_d    = state_q;
      rem_op_d   = rem_op_q;
      neg_quot_d = neg_quot_q;
      neg_rem_d  = neg_rem_q;
      dvd_d      = dvd_q;
      dvs_d      = dvs_q;
      prem_d     = prem_q;
      quot_d     = quot_q;
      result_d   = result_q;
      cnt_d      = cnt_q;
      if (kill) begin
         state_d = DIV_IDLE;
      end else begin
         unique case (state_q)
            DIV_IDLE: begin
               if (accept) begin
                  rem_op_d   = is_rem_op(op);
                  neg_quot_d = dvd_neg ^ dvs_neg;
                  neg_rem_d  = dvd_neg;
                  dvs_d      = dvs_abs;
                  prem_d     = '0;
                  quot_d     = '0;
                  if (div_zero) begin
                     result_d = is_rem_op(op) ? dividend : '1;
                     state_d  = DIV_DONE;
                  end else if (overflow) begin
                     result_d = is_rem_op(op) ? '0 : MOST_NEG;
                     state_d  = DIV_DONE;
                  end else begin
                     dvd_d   = dvd_abs << (RADIX_LOG2 * int'(skip_groups));
                     cnt_d   = skip_groups;
                     state_d = (skip_groups == CNT_W'(N_ITER)) ? DIV_FIX : DIV_ITER;
                  end
               end
            end
            DIV_ITER: begin
               dvd_d  = dvd_q << RADIX_LOG2;
               prem_d = step_prem;
               quot_d = {quot_q[XLEN-RADIX_LOG2-1:0], step_digit};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == LAST_CNT) state_d = DIV_FIX;
            end
            DIV_FIX: begin
               if (rem_op_q) result_d = neg_rem_q ? -prem_q : prem_q;
               else          result_d = neg_quot_q ? -quot_q : quot_q;
               state_d = DIV_DONE;
            end
            DIV_DONE: begin
               if (out_ready) state_d = DIV_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= DIV_IDLE;
         rem_op_q   <= 1'b0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         dvd_q      <= '0;
         dvs_q      <= '0;
         prem_q     <= '0;
         quot_q     <= '0;
         result_q   <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rem_op_q   <= rem_op_d;
         neg_quot_q <= neg_quot_d;
         neg_rem_q  <= neg_rem_d;
         dvd_q      <= dvd_d;
         dvs_q      <= dvs_d;
         prem_q     <= prem_d;
         quot_q     <= quot_d;
         result_q   <= result_d;
         cnt_q      <= cnt_d;
      end
   end

   assign in_ready  = (state_q == DIV_IDLE);
   assign out_valid = (state_q == DIV_DONE);
   assign result    = result_q;

endmodule

// File: tb/tb_div_radix_param.sv
// Self-checking bench for div_radix_param: directed vector table, hand-written handshake,
// kill and reset sequences, and randomized ops against an arithmetic reference model.
module tb_div_radix_param;
   import div_pkg::*;

   localparam int XLEN   = 32;
   localparam int R      = 4;
   localparam int N_ITER = XLEN / R;
   localparam int N_RAND = 1500;
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] dividend;
   logic [XLEN-1:0] divisor;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   int n_vec = 0;
   int n_err = 0;
   logic [XLEN-1:0] exp_q[$];
   logic [XLEN-1:0] last_result;

   div_radix_param #(.XLEN(XLEN), .RADIX_LOG2(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .dividend  (dividend),
      .divisor   (divisor),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   task automatic apply_reset();
      rst = 1'b1; in_valid = 1'b0; op = '0; dividend = '0; divisor = '0;
      kill = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   // ---------------- reference model ----------------
   function automatic logic [XLEN-1:0] ref_result(input logic [1:0] o, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
      logic sgn, rem;
      sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
      rem = (o == DIV_OP_REM) || (o == DIV_OP_REMU);
      if (b == 0) return rem ? a : '1;
      if (sgn && a == MOST_NEG && b == '1) return rem ? '0 : MOST_NEG;
      if (sgn) return rem ? XLEN'($signed(a) % $signed(b)) : XLEN'($signed(a) / $signed(b));
      return rem ? a % b : a / b;
   endfunction

   function automatic int ref_latency(input logic [1:0] o, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
      logic sgn;
      logic [XLEN-1:0] mag;
      int sig;
      sgn = (o == DIV_OP_DIV) || (o == DIV_OP_REM);
      if (b == 0 || (sgn && a == MOST_NEG && b == '1)) return 1;
      mag = (sgn && a[XLEN-1]) ? -a : a;
      sig = 0;
      for (int i = 0; i < XLEN; i++) if (mag[i]) sig = i + 1;
`ifdef DIV_EARLY_OUT_EN
      return (sig + R - 1) / R + 2;
`else
      return (sig >= 0) ? N_ITER + 2 : 0;
`endif
   endfunction

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input int stall, input string tag);
      int lat, waited, exp_lat;
      exp_lat = ref_latency(o, a, b);
      exp_q.push_back(exp);
      waited = 0;
      while (!in_ready && waited < 50) begin @(negedge clk); waited++; end
      check({tag, " in_ready"}, XLEN'(in_ready), 1);
      op = o; dividend = a; divisor = b; in_valid = 1'b1; out_ready = (stall == 0);
      @(negedge clk);
      in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
      lat = 1;
      while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
      check({tag, " latency"}, XLEN'(lat), XLEN'(exp_lat));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check({tag, " hold valid"}, XLEN'(out_valid), 1);
         check({tag, " hold in_ready"}, XLEN'(in_ready), 0);
         check({tag, " hold result"}, result, exp_q[0]);
      end
      out_ready = 1'b1;
      check({tag, " result"}, result, exp_q.pop_front());
      last_result = exp;
      @(negedge clk);
      check({tag, " released"}, XLEN'(out_valid), 0);
   endtask

   task automatic expect_quiet(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check({tag, " no out_valid"}, XLEN'(seen), 0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] exp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [1:0]      r_op;
      logic [XLEN-1:0] r_a, r_b;
      int              kind;

      vecs[0]  = '{DIV_OP_DIVU, 32'd100,        32'd7,          32'd14};
      vecs[1]  = '{DIV_OP_REMU, 32'd100,        32'd7,          32'd2};
      vecs[2]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
      vecs[3]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
      vecs[4]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
      vecs[5]  = '{DIV_OP_DIVU, 32'h1234,       32'd0,          32'hFFFF_FFFF};
      vecs[6]  = '{DIV_OP_REMU, 32'h1234,       32'd0,          32'h1234};
      vecs[7]  = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
      vecs[8]  = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
      vecs[9]  = '{DIV_OP_DIV,  32'h1234,       32'd0,          32'hFFFF_FFFF};
      vecs[10] = '{DIV_OP_REM,  32'h8000_0000,  32'd0,          32'h8000_0000};
      vecs[11] = '{DIV_OP_DIVU, 32'd0,          32'd5,          32'd0};
      vecs[12] = '{DIV_OP_DIV,  32'h8000_0000,  32'd3,          32'hD555_5556};

      apply_reset();
      check("reset in_ready", XLEN'(in_ready), 1);
      check("reset out_valid", XLEN'(out_valid), 0);
      check("reset result", result, 0);

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, 0, $sformatf("vec%0d", i));

      // Back-pressure: result held for 5 cycles with in_ready low.
      run_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 5, "hold");

      // Kill during ITER: accepted at T, kill sampled at T+4.
      op = DIV_OP_DIVU; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("kill accepted", XLEN'(in_ready), 0);
      repeat (3) @(negedge clk);
      kill = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("kill in_ready", XLEN'(in_ready), 1);
      check("kill out_valid", XLEN'(out_valid), 0);
      check("kill result kept", result, last_result);
      expect_quiet("kill", 15);

      // Kill together with in_valid in IDLE: nothing accepted.
      op = DIV_OP_DIVU; dividend = 32'd9; divisor = 32'd3; in_valid = 1'b1; kill = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; kill = 1'b0;
      check("kill+valid in_ready", XLEN'(in_ready), 1);
      expect_quiet("kill+valid", 15);

      // Kill in DONE while out_ready is high: no handshake, result unchanged.
      op = DIV_OP_DIVU; dividend = 32'd100; divisor = 32'd7; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      for (int c = 0; c < 40 && !out_valid; c++) @(negedge clk);
      check("done kill valid seen", XLEN'(out_valid), 1);
      kill = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      kill = 1'b0;
      check("done kill out_valid", XLEN'(out_valid), 0);
      check("done kill in_ready", XLEN'(in_ready), 1);
      check("done kill result", result, 32'd14);

      // Reset mid-ITER: rst sampled at T+3.
      op = DIV_OP_DIVU; dividend = 32'd1000; divisor = 32'd3; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid rst out_valid", XLEN'(out_valid), 0);
      check("mid rst in_ready", XLEN'(in_ready), 1);
      check("mid rst result", result, 0);
      expect_quiet("mid rst", 15);
      run_op(DIV_OP_REMU, 32'd1000, 32'd3, 32'd1, 0, "post rst");

      // Randomized ops with corner-case classes and light back-pressure.
      for (int n = 0; n < N_RAND; n++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = XLEN'($urandom);
         r_b  = XLEN'($urandom);
         kind = $urandom_range(0, 9);
         case (kind)
            0: r_b = '0;
            1: begin r_a = MOST_NEG; r_b = '1; end
            2: r_a = '0;
            3: r_b = XLEN'($urandom_range(1, 20));
            4: r_a = XLEN'($urandom_range(0, 300));
            5: r_b = -XLEN'($urandom_range(1, 20));
            default: ;
         endcase
         run_op(r_op, r_a, r_b, ref_result(r_op, r_a, r_b), $urandom_range(0, 2),
                $sformatf("rnd%0d op%0d 0x%0h/0x%0h", n, r_op, r_a, r_b));
      end

      check("scoreboard drained", XLEN'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
